// File: rtl/cargador_prog_if.sv
// cargador_prog_if: byte-stream input and program-memory write bus of the loader
interface cargador_prog_if #(parameter int ADDR_W = 10);
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic we;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0] wr_data;
  modport master (output rx_data, rx_valid, input rx_ready, we, wr_addr, wr_data);
  modport slave (input rx_data, rx_valid, output rx_ready, we, wr_addr, wr_data);
endinterface

// File: rtl/cargador_prog.sv
// cargador_prog: loads a length-prefixed, checksummed byte stream into program memory
module cargador_prog #(
  parameter int ADDR_W = 10,
  parameter int BASE_ADDR = 0,
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  cargador_prog_if.slave bus,
  output logic cpu_hold,
  output logic busy,
  output logic done,
  output logic error
);
  typedef enum logic [3:0] {IDLE, LEN_H, LEN_L, DAT_H, DAT_L, WRITE, CHK, DONE, ERR} state_t;
  localparam logic [31:0] MAXN = 32'((1 << ADDR_W) - BASE_ADDR);
  state_t state, state_d;
  logic [7:0] len_h, hi, sum;
  logic [ADDR_W:0] cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0] wr_data, n;
  logic [31:0] tmo;
  logic rdy, acc, n_ok, tmo_hit, last;
  assign bus.wr_addr = wr_addr;
  assign bus.wr_data = wr_data;
  assign bus.rx_ready = rdy;
  // handshake, length validation and stall detection
  always_comb begin
    rdy = state inside {LEN_H, LEN_L, DAT_H, DAT_L, CHK};
    acc = rdy && bus.rx_valid;
    n = {len_h, bus.rx_data};
    n_ok = n != 16'd0 && 32'(n) <= MAXN;
    last = cnt == (ADDR_W+1)'(1);
    tmo_hit = TIMEOUT != 0 && rdy && !acc && tmo == 32'(TIMEOUT - 1);
    bus.we = state == WRITE;
    busy = state inside {LEN_H, LEN_L, DAT_H, DAT_L, WRITE, CHK};
    cpu_hold = busy;
    done = state == DONE;
    error = state == ERR;
  end
  // next-state logic; a stall in any byte-waiting state aborts the load
  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE, ERR: state_d = start ? LEN_H : state;
      LEN_H: state_d = acc ? LEN_L : state;
      LEN_L: state_d = acc ? (n_ok ? DAT_H : ERR) : state;
      DAT_H: state_d = acc ? DAT_L : state;
      DAT_L: state_d = acc ? WRITE : state;
      WRITE: state_d = last ? CHK : DAT_H;
      CHK: state_d = acc ? (bus.rx_data == sum ? DONE : ERR) : state;
      default: state_d = IDLE;
    endcase
    if (tmo_hit) state_d = ERR;
  end
  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_d;
  end
  // datapath: length, word assembly, checksum, address and idle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_h <= 8'd0;
      hi <= 8'd0;
      sum <= 8'd0;
      cnt <= '0;
      wr_addr <= ADDR_W'(BASE_ADDR);
      wr_data <= 16'd0;
      tmo <= 32'd0;
    end else begin
      tmo <= (acc || !rdy) ? 32'd0 : tmo + 32'd1;
      case (state)
        IDLE, DONE, ERR: if (start) begin
          sum <= 8'd0;
          wr_addr <= ADDR_W'(BASE_ADDR);
        end
        LEN_H: if (acc) len_h <= bus.rx_data;
        LEN_L: if (acc) cnt <= (ADDR_W+1)'(n);
        DAT_H: if (acc) begin
          hi <= bus.rx_data;
          sum <= sum + bus.rx_data;
        end
        DAT_L: if (acc) begin
          wr_data <= {hi, bus.rx_data};
          sum <= sum + bus.rx_data;
        end
        WRITE: begin
          cnt <= cnt - (ADDR_W+1)'(1);
          if (!last) wr_addr <= wr_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cargador_prog.sv
// tb_cargador_prog: directed streams checked against hand-computed memory contents and flags
module tb_cargador_prog;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, busy, done, error;
  int errors = 0;
  int checks = 0;
  int wcnt = 0;
  int base;
  logic [15:0] mem [0:1023];
  logic [9:0] max_addr = 10'd0;
  cargador_prog_if #(.ADDR_W(10)) bus ();
  cargador_prog #(.ADDR_W(10), .BASE_ADDR(0), .TIMEOUT(50)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.we) begin
    mem[bus.wr_addr] = bus.wr_data;
    wcnt++;
    if (bus.wr_addr > max_addr) max_addr = bus.wr_addr;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    repeat (gap) @(negedge clk);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    k = 0;
    while (!bus.rx_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("rx_ready_wait", 32'(k), 32'd0);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
  endtask
  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    chk({tag, "_we"}, 32'(bus.we), 32'd0);
    chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
  endtask
  initial begin
    logic [7:0] s;
    logic [15:0] w;
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    // good two-word load; a start pulse mid-load must be ignored
    base = wcnt;
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("t1_rx_ready", 32'(bus.rx_ready), 32'd1);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    pulse_start();
    send_byte(8'h34, 0);
    chk("t1_we_latency", 32'(bus.we), 32'd1);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    send_byte(8'hBE, 0);
    chk("t1_wcnt", 32'(wcnt - base), 32'd2);
    chk("t1_mem0", 32'(mem[0]), 32'h1234);
    chk("t1_mem1", 32'(mem[1]), 32'hABCD);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_error", 32'(error), 32'd0);
    chk("t1_cpu_hold_rel", 32'(cpu_hold), 32'd0);
    chk("t1_busy_rel", 32'(busy), 32'd0);
    chk("t1_wr_addr", 32'(bus.wr_addr), 32'd1);
    // bad checksum with rx_valid gaps: words stay written, error flagged
    base = wcnt;
    pulse_start();
    chk("t2_done_cleared", 32'(done), 32'd0);
    send_byte(8'h00, $urandom_range(0, 3));
    send_byte(8'h02, $urandom_range(0, 3));
    send_byte(8'h56, $urandom_range(0, 3));
    send_byte(8'h78, $urandom_range(0, 3));
    send_byte(8'h9A, $urandom_range(0, 3));
    send_byte(8'hBC, $urandom_range(0, 3));
    send_byte(8'h00, $urandom_range(0, 3));
    chk("t2_wcnt", 32'(wcnt - base), 32'd2);
    chk("t2_mem0", 32'(mem[0]), 32'h5678);
    chk("t2_mem1", 32'(mem[1]), 32'h9ABC);
    chk("t2_error", 32'(error), 32'd1);
    chk("t2_done", 32'(done), 32'd0);
    chk("t2_cpu_hold", 32'(cpu_hold), 32'd0);
    // rx_valid while not loading is left unconsumed
    bus.rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("t2_idle_ready", 32'(bus.rx_ready), 32'd0);
    bus.rx_valid = 1'b0;
    // zero length aborts right after LEN_L without a write
    base = wcnt;
    pulse_start();
    chk("t3_error_cleared", 32'(error), 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_wcnt", 32'(wcnt - base), 32'd0);
    // 1025 words exceed the 1024-word memory
    base = wcnt;
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    chk("t4_error", 32'(error), 32'd1);
    chk("t4_wcnt", 32'(wcnt - base), 32'd0);
    // 50 idle cycles in DAT_H time out, 49 do not
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    repeat (49) @(negedge clk);
    chk("t5_busy_49", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t5_error_50", 32'(error), 32'd1);
    chk("t5_cpu_hold", 32'(cpu_hold), 32'd0);
    // asynchronous reset while waiting for a LO byte
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    #2 reset = 1'b0;
    #1 check_idle_outputs("t6");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    // full memory load ends at the last address without wrapping
    base = wcnt;
    max_addr = 10'd0;
    s = 8'h00;
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 1024; i++) begin
      w = 16'(i * 40503 + 17185);
      s = s + w[15:8] + w[7:0];
      send_byte(w[15:8], 0);
      send_byte(w[7:0], 0);
    end
    send_byte(s, 0);
    chk("t7_wcnt", 32'(wcnt - base), 32'd1024);
    chk("t7_done", 32'(done), 32'd1);
    chk("t7_max_addr", 32'(max_addr), 32'h3FF);
    chk("t7_wr_addr", 32'(bus.wr_addr), 32'h3FF);
    chk("t7_mem0", 32'(mem[0]), 32'h4321);
    w = 16'(341 * 40503 + 17185);
    chk("t7_mem155", 32'(mem[10'h155]), 32'(w));
    w = 16'(1023 * 40503 + 17185);
    chk("t7_mem3ff", 32'(mem[10'h3FF]), 32'(w));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
